// File: rtl/mnist_lut_pkg.sv
// Shared constants and vote-bit mapping for the mnist_lut_net output.
// No logic and no latency. Nothing here carries any flow control.
// Contents: class/vote/class-width constants, and mnist_bit_idx(vote, cls, num_class),
// which gives the bit position of one vote inside the flat net output.
package mnist_lut_pkg;

   localparam int MNIST_NUM_CLASS   = 10;
   localparam int MNIST_NUM_VOTE    = 3;
   localparam int MNIST_CLASS_WIDTH = 4;

   // Votes are grouped per sub-network: all classes of vote 0 first, then vote 1, ...
   function automatic int mnist_bit_idx(input int vote, input int cls, input int num_class);
      return vote * num_class + cls;
   endfunction

endpackage

// File: rtl/mnist_lut_vote_argmax.sv
// Combinational argmax over per-class vote counts. On a tie the lowest index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: sum_i   packed per-class counts; element c is the count for class c.
//        class_o winning class index; 0 when no class scored.
//        score_o count of the winner.
//        none_o  1 when every count is zero.
module mnist_lut_vote_argmax
   import mnist_lut_pkg::*;
#(
   parameter int NUM_CLASS   = MNIST_NUM_CLASS,
   parameter int CLASS_WIDTH = MNIST_CLASS_WIDTH,
   parameter int SUM_WIDTH   = 2
)(
   input  logic [NUM_CLASS-1:0][SUM_WIDTH-1:0] sum_i,
   output logic [CLASS_WIDTH-1:0]              class_o,
   output logic [SUM_WIDTH-1:0]                score_o,
   output logic                                none_o
);

   logic [CLASS_WIDTH-1:0] best_cls;
   logic [SUM_WIDTH-1:0]   best_sum;

   // Strict greater-than while scanning upward keeps the lowest index on ties.
   // Starting from best_sum = 0 means that an all-zero input leaves class 0 and score 0.
   always_comb begin
      best_cls = '0;
      best_sum = '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
         if (sum_i[c] > best_sum) begin
            best_sum = sum_i[c];
            best_cls = CLASS_WIDTH'(c);
         end
      end
   end

   assign class_o = best_cls;
   assign score_o = best_sum;
   assign none_o  = (best_sum == '0);

endmodule

// File: rtl/mnist_lut_vote.sv
// Vote counter, argmax and label compare behind mnist_lut_net, with optional accuracy statistics.
// Latency: 3 enabled (cke = 1) cycles from in_valid to out_valid.
// Backpressure: none; a sample is taken on every cycle with in_valid = 1 and cke = 1.
// Ports: clk/reset_n (synchronous, active-low)/cke; in_user/in_data/in_valid from the net;
//        out_user/out_class/out_score/out_none/out_match/out_valid for the result;
//        stat_clear, stat_total and stat_match for the running counters.
// Build option: define MNIST_LUT_VOTE_STAT_EN to build the statistics counters. Without it
//        stat_total and stat_match are 0 and stat_clear is ignored.
module mnist_lut_vote
   import mnist_lut_pkg::*;
#(
   parameter int USER_WIDTH  = 8,
   parameter int NUM_CLASS   = MNIST_NUM_CLASS,
   parameter int NUM_VOTE    = MNIST_NUM_VOTE,
   parameter int CLASS_WIDTH = MNIST_CLASS_WIDTH,
   parameter int SUM_WIDTH   = 2,
   parameter int STAT_WIDTH  = 32
)(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cke,
   input  logic [USER_WIDTH-1:0]         in_user,
   input  logic [NUM_CLASS*NUM_VOTE-1:0] in_data,
   input  logic                          in_valid,
   output logic [USER_WIDTH-1:0]         out_user,
   output logic [CLASS_WIDTH-1:0]        out_class,
   output logic [SUM_WIDTH-1:0]          out_score,
   output logic                          out_none,
   output logic                          out_match,
   output logic                          out_valid,
   input  logic                          stat_clear,
   output logic [STAT_WIDTH-1:0]         stat_total,
   output logic [STAT_WIDTH-1:0]         stat_match
);

   // ---------------- stage 1: per-class vote count ----------------
   logic [NUM_CLASS-1:0][NUM_VOTE-1:0]  vote_bits;
   logic [NUM_CLASS-1:0][SUM_WIDTH-1:0] s1_sum_d;
   logic [NUM_CLASS-1:0][SUM_WIDTH-1:0] s1_sum_q;
   logic [USER_WIDTH-1:0]               s1_user_q;
   logic                                s1_vld_q;

   // Regroup the flat net output so that each class sees its own votes side by side.
   for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
      for (genvar v = 0; v < NUM_VOTE; v++) begin : g_vote
         assign vote_bits[c][v] = in_data[mnist_bit_idx(v, c, NUM_CLASS)];
      end
   end

   always_comb begin
      s1_sum_d = '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
         s1_sum_d[c] = SUM_WIDTH'($countones(vote_bits[c]));
      end
   end

   // ---------------- stage 2: argmax ----------------
   logic [CLASS_WIDTH-1:0] am_class;
   logic [SUM_WIDTH-1:0]   am_score;
   logic                   am_none;

   mnist_lut_vote_argmax #(
      .NUM_CLASS   (NUM_CLASS),
      .CLASS_WIDTH (CLASS_WIDTH),
      .SUM_WIDTH   (SUM_WIDTH)
   ) u_argmax (
      .sum_i   (s1_sum_q),
      .class_o (am_class),
      .score_o (am_score),
      .none_o  (am_none)
   );

   logic [CLASS_WIDTH-1:0] s2_class_q;
   logic [SUM_WIDTH-1:0]   s2_score_q;
   logic                   s2_none_q;
   logic [USER_WIDTH-1:0]  s2_user_q;
   logic                   s2_vld_q;

   // ---------------- stage 3: label compare and output ----------------
   logic                   s3_match_d;
   logic [CLASS_WIDTH-1:0] s3_class_q;
   logic [SUM_WIDTH-1:0]   s3_score_q;
   logic                   s3_none_q;
   logic                   s3_match_q;
   logic [USER_WIDTH-1:0]  s3_user_q;
   logic                   s3_vld_q;

   // An empty vote never counts as a hit, even when the label is 0.
   assign s3_match_d = !s2_none_q && (s2_class_q == s2_user_q[CLASS_WIDTH-1:0]);

   // Reset wins over cke. Valid flags advance on every enabled cycle, so bubbles
   // move through the pipe as well.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_sum_q   <= '0;
         s1_user_q  <= '0;
         s1_vld_q   <= 1'b0;
         s2_class_q <= '0;
         s2_score_q <= '0;
         s2_none_q  <= 1'b0;
         s2_user_q  <= '0;
         s2_vld_q   <= 1'b0;
         s3_class_q <= '0;
         s3_score_q <= '0;
         s3_none_q  <= 1'b0;
         s3_match_q <= 1'b0;
         s3_user_q  <= '0;
         s3_vld_q   <= 1'b0;
      end else if (cke) begin
         s1_sum_q   <= s1_sum_d;
         s1_user_q  <= in_user;
         s1_vld_q   <= in_valid;
         s2_class_q <= am_class;
         s2_score_q <= am_score;
         s2_none_q  <= am_none;
         s2_user_q  <= s1_user_q;
         s2_vld_q   <= s1_vld_q;
         s3_class_q <= s2_class_q;
         s3_score_q <= s2_score_q;
         s3_none_q  <= s2_none_q;
         s3_match_q <= s3_match_d;
         s3_user_q  <= s2_user_q;
         s3_vld_q   <= s2_vld_q;
      end
   end

   assign out_user  = s3_user_q;
   assign out_class = s3_class_q;
   assign out_score = s3_score_q;
   assign out_none  = s3_none_q;
   assign out_match = s3_match_q;
   assign out_valid = s3_vld_q;

   // ---------------- statistics ----------------
`ifdef MNIST_LUT_VOTE_STAT_EN
   logic [STAT_WIDTH-1:0] stat_total_q;
   logic [STAT_WIDTH-1:0] stat_match_q;

   // The counters advance on the same edge that loads a sample into stage 3. This way
   // stat_* already include the sample shown on out_*. A clear on that edge drops the
   // sample.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stat_total_q <= '0;
         stat_match_q <= '0;
      end else if (cke) begin
         if (stat_clear) begin
            stat_total_q <= '0;
            stat_match_q <= '0;
         end else begin
            if (s2_vld_q && (stat_total_q != '1)) begin
               stat_total_q <= stat_total_q + STAT_WIDTH'(1);
            end
            if (s2_vld_q && s3_match_d && (stat_match_q != '1)) begin
               stat_match_q <= stat_match_q + STAT_WIDTH'(1);
            end
         end
      end
   end

   assign stat_total = stat_total_q;
   assign stat_match = stat_match_q;
`else
   logic stat_clear_unused;
   assign stat_clear_unused = stat_clear;
   assign stat_total = '0;
   assign stat_match = '0;
`endif

endmodule

// File: tb/tb_mnist_lut_vote.sv
// Directed bench for mnist_lut_vote: latency, argmax/tie/none cases, cke-gated streaming
// against a reference model, statistics clear/saturation, and reset mid-stream.
// Expectations for stat_* follow whether MNIST_LUT_VOTE_STAT_EN is defined.
module tb_mnist_lut_vote;

`ifdef MNIST_LUT_VOTE_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cke;
   logic [7:0]  in_user;
   logic [29:0] in_data;
   logic        in_valid;
   logic        stat_clear;

   logic [7:0]  out_user;
   logic [3:0]  out_class;
   logic [1:0]  out_score;
   logic        out_none, out_match, out_valid;
   logic [31:0] stat_total, stat_match;

   logic [7:0]  sat_user;
   logic [3:0]  sat_class;
   logic [1:0]  sat_score;
   logic        sat_none, sat_match, sat_valid;
   logic [1:0]  sat_total, sat_mcnt;

   always #5 clk = ~clk;

   mnist_lut_vote dut (
      .clk(clk), .reset_n(reset_n), .cke(cke),
      .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
      .out_user(out_user), .out_class(out_class), .out_score(out_score),
      .out_none(out_none), .out_match(out_match), .out_valid(out_valid),
      .stat_clear(stat_clear), .stat_total(stat_total), .stat_match(stat_match)
   );

   // Narrow statistics so saturation is reachable in a short run.
   mnist_lut_vote #(.STAT_WIDTH(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .cke(cke),
      .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
      .out_user(sat_user), .out_class(sat_class), .out_score(sat_score),
      .out_none(sat_none), .out_match(sat_match), .out_valid(sat_valid),
      .stat_clear(stat_clear), .stat_total(sat_total), .stat_match(sat_mcnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: bit i votes for class i%10. The scan runs downward with >=, so the
   // lowest index wins a tie. Returns {class[3:0], score[1:0], none}.
   function automatic logic [6:0] ref_vote(input logic [29:0] d);
      int cnt[10];
      int best_c;
      int best_s;
      for (int c = 0; c < 10; c++) cnt[c] = 0;
      for (int i = 0; i < 30; i++) if (d[i]) cnt[i % 10]++;
      best_c = 0;
      best_s = 0;
      for (int c = 9; c >= 0; c--) begin
         if (cnt[c] > 0 && cnt[c] >= best_s) begin
            best_s = cnt[c];
            best_c = c;
         end
      end
      return {4'(best_c), 2'(best_s), (best_s == 0)};
   endfunction

   // Present one sample, then check that out_valid rises on exactly the third enabled edge.
   task automatic send(input logic [29:0] d, input logic [7:0] u);
      in_valid = 1'b1; in_data = d; in_user = u;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_user = '0;
      @(posedge clk); #1;
      chk("lat_early", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("lat_valid", out_valid, 1'b1);
   endtask

   logic [15:0] exp_q[$];
   logic [15:0] exp_rec, got_rec;
   logic [6:0]  rc;
   logic [3:0]  lbl;
   logic        m;
   int sent, popped, n_match_exp;
   int exp_total, exp_mt;

   initial begin
      reset_n = 1'b0; cke = 1'b1; in_user = '0; in_data = '0; in_valid = 1'b0; stat_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_class", out_class, 4'd0);
      chk("rst_total", stat_total, 32'd0);
      chk("rst_match", stat_match, 32'd0);
      reset_n = 1'b1;

      // Class 3 wins with all three votes.
      send(30'h0080_2008, 8'h03);
      chk("t1_class", out_class, 4'd3);
      chk("t1_score", out_score, 2'd3);
      chk("t1_match", out_match, 1'b1);
      chk("t1_none",  out_none,  1'b0);
      chk("t1_user",  out_user,  8'h03);

      // Classes 2 and 7 tie with one vote each, so the lower index wins.
      send(30'h0000_0084, 8'h07);
      chk("t2_class", out_class, 4'd2);
      chk("t2_score", out_score, 2'd1);
      chk("t2_match", out_match, 1'b0);

      // No votes at all. Label 0 must not count as a hit.
      send(30'h0, 8'h00);
      chk("t3_none",  out_none,  1'b1);
      chk("t3_class", out_class, 4'd0);
      chk("t3_score", out_score, 2'd0);
      chk("t3_match", out_match, 1'b0);

      // Class 9 has two votes and beats class 5.
      send(30'h0008_0220, 8'h09);
      chk("t4_class", out_class, 4'd9);
      chk("t4_score", out_score, 2'd2);
      chk("t4_match", out_match, 1'b1);

      // Classes 1 and 4 tie at two votes. Only the low nibble of the user field is the label.
      send(30'h0120_4002, 8'hA1);
      chk("t5_class", out_class, 4'd1);
      chk("t5_score", out_score, 2'd2);
      chk("t5_match", out_match, 1'b1);
      chk("t5_user",  out_user,  8'hA1);

      chk("dir_total", stat_total, STAT_EN ? 32'd5 : 32'd0);
      chk("dir_match", stat_match, STAT_EN ? 32'd3 : 32'd0);

      // Stream 100 samples back to back with cke toggling at random.
      stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
      sent = 0; popped = 0; n_match_exp = 0;
      for (int cyc = 0; cyc < 3000 && popped < 100; cyc++) begin
         cke = ($urandom_range(0, 3) != 0);
         if (sent < 100) begin
            in_valid = 1'b1;
            in_data  = 30'($urandom);
            rc       = ref_vote(in_data);
            lbl      = ($urandom_range(0, 1) != 0) ? rc[6:3] : 4'($urandom_range(0, 9));
            in_user  = {4'($urandom_range(0, 15)), lbl};
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         if (in_valid && cke) begin
            m = !rc[0] && (rc[6:3] == in_user[3:0]);
            exp_q.push_back({in_user, rc, m});
            sent++;
            if (m) n_match_exp++;
         end
         #1;
         if (cke && out_valid) begin
            got_rec = {out_user, out_class, out_score, out_none, out_match};
            if (exp_q.size() == 0) begin
               chk("stream_extra", got_rec, 16'h0);
            end else begin
               exp_rec = exp_q.pop_front();
               chk("stream_rec", got_rec, exp_rec);
            end
            popped++;
         end
      end
      cke = 1'b1; in_valid = 1'b0;
      chk("stream_count", popped, 100);
      chk("stream_left", exp_q.size(), 0);
      exp_total = STAT_EN ? 100 : 0;
      exp_mt    = STAT_EN ? n_match_exp : 0;
      chk("stream_total", stat_total, exp_total);
      chk("stream_match", stat_match, exp_mt);
      chk("sat_total", sat_total, STAT_EN ? 2'd3 : 2'd0);
      chk("sat_match", sat_mcnt, (STAT_EN && n_match_exp >= 3) ? 2'd3 : 2'(exp_mt));

      // Clear on the same edge that completes a sample: the sample is dropped.
      in_valid = 1'b1; in_data = 30'h0080_2008; in_user = 8'h03;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      stat_clear = 1'b1;
      @(posedge clk); #1;
      stat_clear = 1'b0;
      chk("clr_valid", out_valid, 1'b1);
      chk("clr_total", stat_total, 32'd0);
      chk("clr_match", stat_match, 32'd0);

      // A clear while cke = 0 is ignored, and the outputs hold.
      send(30'h0080_2008, 8'h03);
      chk("hold_pre", stat_total, STAT_EN ? 32'd1 : 32'd0);
      cke = 1'b0; stat_clear = 1'b1;
      @(posedge clk); #1;
      chk("hold_total", stat_total, STAT_EN ? 32'd1 : 32'd0);
      chk("hold_valid", out_valid, 1'b1);
      cke = 1'b1;
      @(posedge clk); #1;
      stat_clear = 1'b0;
      chk("clr2_total", stat_total, 32'd0);

      // Reset with two samples in flight and one counted sample.
      send(30'h0000_0084, 8'h02);
      in_valid = 1'b1; in_data = 30'h0080_2008; in_user = 8'h03;
      @(posedge clk); #1;
      in_data = 30'h0000_0084; in_user = 8'h02;
      @(posedge clk); #1;
      in_valid = 1'b0; reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("mrst_total", stat_total, 32'd0);
      chk("mrst_user", out_user, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mrst_valid", out_valid, 1'b0);
      end
      chk("mrst_match", stat_match, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mnist_lut_vote.md
Name: mnist_lut_vote

Overview:
Classification back end placed directly downstream of mnist_lut_net. Consumes its 30-bit output: 10 classes x 3 independent sub-network votes, bit index = vote*10 + class. Per sample it counts votes per class, picks the winning class, and compares it against the label carried in the user field. Optionally accumulates running accuracy statistics for the OLED/host readout.

Parameters:
USER_WIDTH, 8, width of the sideband passed through; low CLASS_WIDTH bits are the ground-truth label.
NUM_CLASS, 10, number of classes.
NUM_VOTE, 3, number of votes per class.
CLASS_WIDTH, 4, width of the class index, >= clog2(NUM_CLASS).
SUM_WIDTH, 2, width of a per-class vote count, >= clog2(NUM_VOTE+1).
STAT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous reset, active-low.
cke  in  1  clock enable; 0 freezes every register.
in_user  in  USER_WIDTH  sideband from mnist_lut_net out_user.
in_data  in  NUM_CLASS*NUM_VOTE  votes from mnist_lut_net out_data.
in_valid  in  1  input qualifier.
out_user  out  USER_WIDTH  delayed in_user.
out_class  out  CLASS_WIDTH  winning class index.
out_score  out  SUM_WIDTH  vote count of the winner.
out_none  out  1  1 when every class scored 0.
out_match  out  1  out_class == in_user[CLASS_WIDTH-1:0], and out_none == 0.
out_valid  out  1  output qualifier.
stat_clear  in  1  clears statistics counters.
stat_total  out  STAT_WIDTH  number of valid samples counted.
stat_match  out  STAT_WIDTH  number of matching samples counted.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. While reset_n = 0 at a clk edge, all valid flags, out_* and stat_* registers go to 0. Data registers need no reset but are cleared anyway.
- No backpressure: a sample is accepted every cycle where in_valid = 1 and cke = 1.
- Pipeline: 3 stages; out_valid follows in_valid by exactly 3 enabled (cke = 1) cycles.
- Stage 1: sum[c] = number of set bits among in_data[v*NUM_CLASS + c] for v = 0..NUM_VOTE-1, unsigned, SUM_WIDTH bits, no overflow. User and valid are registered alongside.
- Stage 2: argmax over sum[0..NUM_CLASS-1] using strict greater-than, scanning from class 0 upward. On a tie the lowest index wins. If every sum is 0: class = 0, score = 0, none = 1.
- Stage 3: registers class, score, none, user and valid; computes match.
- Data fields are don't-care when valid = 0, but valid flags always propagate, including bubbles.
- cke = 0: all pipeline and statistics registers hold; outputs stay constant.
- Statistics, updated in stage 3 when cke = 1:
  - stat_total increments on each out_valid sample.
  - stat_match increments on each sample with out_match = 1.
  - Both counters saturate at all-ones.
  - stat_clear = 1 has priority: both counters go to 0, and a sample completing in the same cycle is not counted.
  - stat_clear is honoured only when cke = 1.
- Reset mid-stream: in-flight samples are discarded; out_valid is 0 for the first 3 enabled cycles after release.

Optional Feature:
Macro MNIST_LUT_VOTE_STAT_EN.
- Defined: stat_total and stat_match counters are built as described above.
- Undefined: counters are omitted; stat_total and stat_match are tied to 0; stat_clear is ignored. The port list is unchanged.

Decomposition:
- Shared package mnist_lut_pkg holds:
  - constants MNIST_NUM_CLASS = 10, MNIST_NUM_VOTE = 3, MNIST_CLASS_WIDTH = 4;
  - the bit-index mapping vote*NUM_CLASS + class, also used by mnist_lut_net's consumers.
- One sub-module, mnist_lut_vote_argmax: combinational tie-lowest argmax over NUM_CLASS counts, returning class, score and none. Instantiated in stage 2 so it can be unit-tested alone.

Test Plan:
1. in_data with bits 3, 13, 23 set (class 3, all 3 votes), user = 3 -> exactly 3 cycles later: out_valid = 1, out_class = 3, out_score = 3, out_match = 1, out_none = 0.
2. Tie: bits 2 and 7 set, user = 7 -> out_class = 2, out_score = 1, out_match = 0.
3. in_data = 0, user = 0 -> out_none = 1, out_class = 0, out_match = 0.
4. Streaming 100 back-to-back samples with cke toggling pseudo-randomly -> outputs match a reference model in order; stat_total = 100; no sample is lost or duplicated while cke = 0.
5. Statistics: stat_clear asserted on the cycle a sample completes -> both counters read 0 next cycle. Preload stat_total to 2^32-1 via a forced counter -> it stays saturated at 2^32-1.
6. reset_n pulsed low for 1 cycle with 2 samples in flight -> out_valid stays 0 for 3 cycles after release; stat_* = 0. Build without MNIST_LUT_VOTE_STAT_EN -> stat_* constantly 0.
